// File: rtl/lane_note_sched_if.sv
// Signal bundle between the game sequencer/renderers and the lane note scheduler.
// The master drives spawn requests, frame ticks and buttons; the slave returns lane status.
interface lane_note_sched_if #(
  parameter int NUM_LANES = 4
);
  logic                      frame_tick;
  logic                      spawn_valid;
  logic [1:0]                spawn_lane;
  logic                      spawn_ready;
  logic [NUM_LANES-1:0]      hit_btn;
  logic [NUM_LANES-1:0]      note_active;
  logic [10*NUM_LANES-1:0]   note_row;
  logic [NUM_LANES-1:0]      hit_flash;
  logic [NUM_LANES-1:0]      miss_flash;
  logic                      hit_pulse;
  logic                      miss_pulse;
  logic [7:0]                score;

  modport master (
    output frame_tick, spawn_valid, spawn_lane, hit_btn,
    input  spawn_ready, note_active, note_row, hit_flash, miss_flash,
           hit_pulse, miss_pulse, score
  );

  modport slave (
    input  frame_tick, spawn_valid, spawn_lane, hit_btn,
    output spawn_ready, note_active, note_row, hit_flash, miss_flash,
           hit_pulse, miss_pulse, score
  );
endinterface

// File: rtl/lane_note_sched.sv
// Per-lane falling-note scheduler: spawns notes, drops them once per frame,
// judges button presses against the hit window and keeps a saturating score.
module lane_note_sched #(
  parameter int NUM_LANES    = 4,
  parameter int FALL_STEP    = 4,
  parameter int HIT_ROW_LO   = 400,
  parameter int HIT_ROW_HI   = 440,
  parameter int BOTTOM_ROW   = 480,
  parameter int FLASH_FRAMES = 8
) (
  input logic              clk,
  input logic              reset,
  lane_note_sched_if.slave bus
);

  localparam int          CNT_W    = $clog2(FLASH_FRAMES + 1);
  localparam int          HC_W     = $clog2(NUM_LANES + 1);
  localparam logic [10:0] L_STEP   = 11'(FALL_STEP);
  localparam logic [10:0] L_LO     = 11'(HIT_ROW_LO);
  localparam logic [10:0] L_HI     = 11'(HIT_ROW_HI);
  localparam logic [10:0] L_BOTTOM = 11'(BOTTOM_ROW);
  localparam logic [CNT_W-1:0] L_FLASH = CNT_W'(FLASH_FRAMES);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FALLING,
    ST_HIT,
    ST_MISS
  } lane_state_t;

  logic [NUM_LANES-1:0]    w_idle;
  logic [NUM_LANES-1:0]    w_hit;
  logic [NUM_LANES-1:0]    w_miss;
  logic [NUM_LANES-1:0]    w_active;
  logic [NUM_LANES-1:0]    w_hit_flash;
  logic [NUM_LANES-1:0]    w_miss_flash;
  logic [10*NUM_LANES-1:0] w_note_row;
  logic                    w_spawn_ready;
  logic [HC_W-1:0]         w_hit_cnt;
  logic [8:0]              w_score_sum;

  logic [7:0]              r_score;
  logic                    r_hit_pulse;
  logic                    r_miss_pulse;

  // Out-of-range lane indices never match any lane, so they are never ready.
  always_comb begin
    w_spawn_ready = 1'b0;
    for (int i = 0; i < NUM_LANES; i++) begin
      if (bus.spawn_lane == 2'(i) && w_idle[i]) begin
        w_spawn_ready = 1'b1;
      end
    end
  end

  generate
    for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_lane
      lane_state_t      r_state;
      logic [9:0]       r_row;
      logic [CNT_W-1:0] r_cnt;
      logic             w_spawn_sel;
      logic [10:0]      w_row_adv;

      assign w_spawn_sel = bus.spawn_valid && w_spawn_ready && (bus.spawn_lane == 2'(gi));
      assign w_row_adv   = {1'b0, r_row} + L_STEP;

      // A valid press is judged on the pre-increment row and pre-empts the tick.
      assign w_hit[gi]  = (r_state == ST_FALLING) && bus.hit_btn[gi] &&
                          ({1'b0, r_row} >= L_LO) && ({1'b0, r_row} <= L_HI);
      assign w_miss[gi] = (r_state == ST_FALLING) && !w_hit[gi] && bus.frame_tick &&
                          (w_row_adv >= L_BOTTOM);

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          r_state <= ST_IDLE;
          r_row   <= '0;
          r_cnt   <= '0;
        end else begin
          case (r_state)
            ST_IDLE: begin
              if (w_spawn_sel) begin
                r_state <= ST_FALLING;
                r_row   <= '0;
              end
            end
            ST_FALLING: begin
              if (w_hit[gi]) begin
                r_state <= ST_HIT;
                r_cnt   <= L_FLASH;
              end else if (bus.frame_tick) begin
                r_row <= w_row_adv[9:0];
                if (w_miss[gi]) begin
                  r_state <= ST_MISS;
                  r_cnt   <= L_FLASH;
                end
              end
            end
            ST_HIT, ST_MISS: begin
              if (bus.frame_tick) begin
                if (r_cnt <= CNT_W'(1)) begin
                  r_state <= ST_IDLE;
                  r_cnt   <= '0;
                end else begin
                  r_cnt <= r_cnt - CNT_W'(1);
                end
              end
            end
            default: r_state <= ST_IDLE;
          endcase
        end
      end

      assign w_idle[gi]                = (r_state == ST_IDLE);
      assign w_active[gi]              = (r_state == ST_FALLING);
      assign w_hit_flash[gi]           = (r_state == ST_HIT);
      assign w_miss_flash[gi]          = (r_state == ST_MISS);
      assign w_note_row[gi*10 +: 10]   = r_row;
    end
  endgenerate

  always_comb begin
    w_hit_cnt = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      w_hit_cnt = w_hit_cnt + HC_W'(w_hit[i]);
    end
  end

  assign w_score_sum = {1'b0, r_score} + 9'(w_hit_cnt);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_score      <= '0;
      r_hit_pulse  <= 1'b0;
      r_miss_pulse <= 1'b0;
    end else begin
      r_score      <= w_score_sum[8] ? 8'hFF : w_score_sum[7:0];
      r_hit_pulse  <= |w_hit;
      r_miss_pulse <= |w_miss;
    end
  end

  assign bus.spawn_ready = w_spawn_ready;
  assign bus.note_active = w_active;
  assign bus.note_row    = w_note_row;
  assign bus.hit_flash   = w_hit_flash;
  assign bus.miss_flash  = w_miss_flash;
  assign bus.hit_pulse   = r_hit_pulse;
  assign bus.miss_pulse  = r_miss_pulse;
  assign bus.score       = r_score;

endmodule

// File: tb/tb_lane_note_sched.sv
// Directed bench for lane_note_sched: an operation table with expected lane
// status after each step, then hand-written multi-lane scoring/saturation rounds.
module tb_lane_note_sched;

  logic clk;
  logic reset;
  int   checks;
  int   failures;
  int   exp_score;

  lane_note_sched_if #(.NUM_LANES(4)) bus ();

  lane_note_sched dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef enum int {OP_RESET, OP_SPAWN, OP_TICKS, OP_HIT, OP_HIT_TICK, OP_SPAWN_TICK, OP_IDLE} op_e;

  typedef struct {
    op_e        op;
    int         arg;    // lane for spawns, button mask for hits
    int         n;      // repeat count for ticks/idle
    int         chk;    // lane whose row and spawn_ready are checked
    logic [3:0] act;
    logic [9:0] row;
    logic [7:0] score;
    logic       hp;
    logic       mp;
    logic [3:0] hf;
    logic [3:0] mf;
    logic       rdy;
  } vec_t;

  localparam int NV = 32;
  vec_t vecs [NV];

  task automatic check(input string nm, input int idx, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s step %0d: got %0d expected %0d", nm, idx, got, exp);
    end
  endtask

  // Inputs are applied at a falling edge, cover one rising edge, and are cleared at the next falling edge.
  task automatic cyc(input logic tick, input logic sv, input logic [1:0] sl, input logic [3:0] hb);
    bus.frame_tick  = tick;
    bus.spawn_valid = sv;
    bus.spawn_lane  = sl;
    bus.hit_btn     = hb;
    @(negedge clk);
    bus.frame_tick  = 1'b0;
    bus.spawn_valid = 1'b0;
    bus.hit_btn     = 4'b0;
  endtask

  task automatic round(input logic [3:0] mask, input int idx);
    int hits;
    for (int l = 0; l < 4; l++) cyc(1'b0, 1'b1, 2'(l), 4'b0);
    repeat (100) cyc(1'b1, 1'b0, 2'd0, 4'b0);
    cyc(1'b0, 1'b0, 2'd0, mask);
    hits = 0;
    for (int l = 0; l < 4; l++) hits += int'(mask[l]);
    exp_score = (exp_score + hits > 255) ? 255 : exp_score + hits;
    #1;
    check("round_score", idx, 32'(bus.score), 32'(exp_score));
    check("round_hit_pulse", idx, 32'(bus.hit_pulse), 32'(mask != 4'b0));
    check("round_hit_flash", idx, 32'(bus.hit_flash), 32'(mask));
    repeat (30) cyc(1'b1, 1'b0, 2'd0, 4'b0);
    check("round_all_idle", idx, 32'(bus.note_active | bus.hit_flash | bus.miss_flash), 32'd0);
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    exp_score = 0;
    reset           = 1'b1;
    bus.frame_tick  = 1'b0;
    bus.spawn_valid = 1'b0;
    bus.spawn_lane  = 2'd0;
    bus.hit_btn     = 4'b0;

    //          op             arg      n    chk  act      row   score hp    mp    hf       mf       rdy
    vecs[0]  = '{OP_RESET,      0,       0,   0,   4'b0000, 10'd0,   8'd0, 1'b0, 1'b0, 4'b0000, 4'b0000, 1'b1};
    vecs[1]  = '{OP_SPAWN,      0,       0,   0,   4'b0001, 10'd0,   8'd0, 1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0};
    vecs[2]  = '{OP_TICKS,      0,       50,  0,   4'b0001, 10'd200, 8'd0, 1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0};
    vecs[3]  = '{OP_RESET,      0,       0,   0,   4'b0000, 10'd0,   8'd0, 1'b0, 1'b0, 4'b0000, 4'b0000, 1'b1};
    vecs[4]  = '{OP_SPAWN,      2,       0,   2,   4'b0100, 10'd0,   8'd0, 1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0};
    vecs[5]  = '{OP_TICKS,      0,       100, 2,   4'b0100, 10'd400, 8'd0, 1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0};
    vecs[6]  = '{OP_HIT,        4'b0100, 0,   2,   4'b0000, 10'd400, 8'd1, 1'b1, 1'b0, 4'b0100, 4'b0000, 1'b0};
    vecs[7]  = '{OP_IDLE,       0,       1,   2,   4'b0000, 10'd400, 8'd1, 1'b0, 1'b0, 4'b0100, 4'b0000, 1'b0};
    vecs[8]  = '{OP_TICKS,      0,       7,   2,   4'b0000, 10'd400, 8'd1, 1'b0, 1'b0, 4'b0100, 4'b0000, 1'b0};
    vecs[9]  = '{OP_TICKS,      0,       1,   2,   4'b0000, 10'd400, 8'd1, 1'b0, 1'b0, 4'b0000, 4'b0000, 1'b1};
    vecs[10] = '{OP_SPAWN,      1,       0,   1,   4'b0010, 10'd0,   8'd1, 1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0};
    vecs[11] = '{OP_TICKS,      0,       99,  1,   4'b0010, 10'd396, 8'd1, 1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0};
    vecs[12] = '{OP_HIT,        4'b0010, 0,   1,   4'b0010, 10'd396, 8'd1, 1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0};
    vecs[13] = '{OP_TICKS,      0,       12,  1,   4'b0010, 10'd444, 8'd1, 1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0};
    vecs[14] = '{OP_HIT,        4'b0010, 0,   1,   4'b0010, 10'd444, 8'd1, 1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0};
    vecs[15] = '{OP_TICKS,      0,       9,   1,   4'b0000, 10'd480, 8'd1, 1'b0, 1'b1, 4'b0000, 4'b0010, 1'b0};
    vecs[16] = '{OP_HIT,        4'b0010, 0,   1,   4'b0000, 10'd480, 8'd1, 1'b0, 1'b0, 4'b0000, 4'b0010, 1'b0};
    vecs[17] = '{OP_TICKS,      0,       8,   1,   4'b0000, 10'd480, 8'd1, 1'b0, 1'b0, 4'b0000, 4'b0000, 1'b1};
    vecs[18] = '{OP_SPAWN,      0,       0,   0,   4'b0001, 10'd0,   8'd1, 1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0};
    vecs[19] = '{OP_TICKS,      0,       110, 0,   4'b0001, 10'd440, 8'd1, 1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0};
    vecs[20] = '{OP_HIT_TICK,   4'b0001, 0,   0,   4'b0000, 10'd440, 8'd2, 1'b1, 1'b0, 4'b0001, 4'b0000, 1'b0};
    vecs[21] = '{OP_TICKS,      0,       8,   0,   4'b0000, 10'd440, 8'd2, 1'b0, 1'b0, 4'b0000, 4'b0000, 1'b1};
    vecs[22] = '{OP_SPAWN,      0,       0,   0,   4'b0001, 10'd0,   8'd2, 1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0};
    vecs[23] = '{OP_TICKS,      0,       111, 0,   4'b0001, 10'd444, 8'd2, 1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0};
    vecs[24] = '{OP_HIT_TICK,   4'b0001, 0,   0,   4'b0001, 10'd448, 8'd2, 1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0};
    vecs[25] = '{OP_TICKS,      0,       8,   0,   4'b0000, 10'd480, 8'd2, 1'b0, 1'b1, 4'b0000, 4'b0001, 1'b0};
    vecs[26] = '{OP_TICKS,      0,       8,   0,   4'b0000, 10'd480, 8'd2, 1'b0, 1'b0, 4'b0000, 4'b0000, 1'b1};
    vecs[27] = '{OP_SPAWN,      3,       0,   3,   4'b1000, 10'd0,   8'd2, 1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0};
    vecs[28] = '{OP_TICKS,      0,       5,   3,   4'b1000, 10'd20,  8'd2, 1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0};
    vecs[29] = '{OP_SPAWN,      3,       0,   3,   4'b1000, 10'd20,  8'd2, 1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0};
    vecs[30] = '{OP_SPAWN_TICK, 0,       0,   0,   4'b1001, 10'd0,   8'd2, 1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0};
    vecs[31] = '{OP_IDLE,       0,       1,   3,   4'b1001, 10'd24,  8'd2, 1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0};

    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    for (int v = 0; v < NV; v++) begin
      case (vecs[v].op)
        OP_RESET: begin
          reset = 1'b1;
          #2;
          check("async_reset_active", v, 32'(bus.note_active), 32'd0);
          @(negedge clk);
          reset = 1'b0;
        end
        OP_SPAWN:      cyc(1'b0, 1'b1, 2'(vecs[v].arg), 4'b0);
        OP_TICKS:      repeat (vecs[v].n) cyc(1'b1, 1'b0, 2'd0, 4'b0);
        OP_HIT:        cyc(1'b0, 1'b0, 2'd0, 4'(vecs[v].arg));
        OP_HIT_TICK:   cyc(1'b1, 1'b0, 2'd0, 4'(vecs[v].arg));
        OP_SPAWN_TICK: cyc(1'b1, 1'b1, 2'(vecs[v].arg), 4'b0);
        default:       repeat (vecs[v].n) cyc(1'b0, 1'b0, 2'd0, 4'b0);
      endcase
      bus.spawn_lane = 2'(vecs[v].chk);
      #1;
      check("note_active", v, 32'(bus.note_active), 32'(vecs[v].act));
      check("note_row", v, 32'(bus.note_row[vecs[v].chk*10 +: 10]), 32'(vecs[v].row));
      check("score", v, 32'(bus.score), 32'(vecs[v].score));
      check("hit_pulse", v, 32'(bus.hit_pulse), 32'(vecs[v].hp));
      check("miss_pulse", v, 32'(bus.miss_pulse), 32'(vecs[v].mp));
      check("hit_flash", v, 32'(bus.hit_flash), 32'(vecs[v].hf));
      check("miss_flash", v, 32'(bus.miss_flash), 32'(vecs[v].mf));
      check("spawn_ready", v, 32'(bus.spawn_ready), 32'(vecs[v].rdy));
      $display("step %0d op=%s lane=%0d active=%b row=%0d score=%0d", v, vecs[v].op.name(),
               vecs[v].chk, bus.note_active, bus.note_row[vecs[v].chk*10 +: 10], bus.score);
    end

    // Multi-lane scoring: 8 -> 10, then the 4-lane hit 10 -> 14, then run up to saturation.
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    exp_score = 0;
    round(4'b1111, 100);
    round(4'b1111, 101);
    round(4'b0011, 102);
    round(4'b1111, 103);
    $display("multi-lane hit score=%0d", bus.score);
    for (int r = 0; r < 60; r++) round(4'b1111, 200 + r);
    $display("pre-saturation score=%0d", bus.score);
    round(4'b1111, 300);
    round(4'b0001, 301);
    $display("saturated score=%0d hit_pulse_seen", bus.score);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
